// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified-memory arbiter.
// Owner encoding for the one-cycle response register.
package mem_arb_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_IF,
    RESP_D_RD,
    RESP_D_WR
  } resp_e;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-ported unified memory.
// Data wins by default; a saturating starve counter forces fetch through.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [WORD_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [BE_W-1:0]   d_be_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [WORD_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [WORD_W-1:0] d_rdata_o,
  output logic              mem_en_o,
  output logic [BE_W-1:0]   mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  input  logic [WORD_W-1:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q, starve_d;
  resp_e            resp_q, resp_d;
  logic             starved;
  logic             if_gnt;
  logic             d_gnt;
  logic             d_store;

  // Grants are gated by reset so nothing reaches memory while held.
  always_comb begin
    starved = (starve_q == CNT_MAX);
    d_gnt   = rst_ni & d_req_i & ~(if_req_i & starved);
    if_gnt  = rst_ni & if_req_i & ~d_gnt;
    d_store = d_gnt & d_we_i;
  end

  always_comb begin
    starve_d = '0;
    if (if_req_i && !if_gnt) begin
      starve_d = starved ? starve_q : starve_q + CNT_W'(1);
    end
  end

  always_comb begin
    resp_d = RESP_NONE;
    unique case (1'b1)
      if_gnt:             resp_d = RESP_IF;
      d_gnt && d_we_i:    resp_d = RESP_D_WR;
      d_gnt && !d_we_i:   resp_d = RESP_D_RD;
      default:            resp_d = RESP_NONE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
      resp_q   <= RESP_NONE;
    end else begin
      starve_q <= starve_d;
      resp_q   <= resp_d;
    end
  end

  always_comb begin
    if_gnt_o    = if_gnt;
    d_gnt_o     = d_gnt;
    mem_en_o    = if_gnt | d_gnt;
    mem_we_o    = d_store ? d_be_i : '0;
    mem_wdata_o = d_store ? d_wdata_i : '0;
    mem_addr_o  = '0;
    if (d_gnt) begin
      mem_addr_o = d_addr_i;
    end else if (if_gnt) begin
      mem_addr_o = if_addr_i;
    end
  end

  always_comb begin
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = '0;
    unique case (resp_q)
      RESP_IF: begin
        if_rvalid_o = 1'b1;
        if_rdata_o  = mem_rdata_i;
      end
      RESP_D_RD: begin
        d_rvalid_o = 1'b1;
        d_rdata_o  = mem_rdata_i;
      end
      RESP_D_WR: begin
        d_rvalid_o = 1'b1;
      end
      default: begin
        if_rvalid_o = 1'b0;
      end
    endcase
  end

endmodule
